// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor (pipe_adder).
// out_flags only exists when ADDER_FLAGS_EN is defined.
package adder_pkg;

  localparam int unsigned FLAG_W = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational S-bit ripple-carry slice; also exposes the carry entering its MSB
// so the last stage can form the signed-overflow flag.
module adder_slice
  import adder_pkg::*;
#(
  parameter int unsigned S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         c_in,
  output logic [S-1:0] s,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [S:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < S; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out    = c[S];
  assign c_msb_in = c[S-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one S-bit slice per stage, valid/ready with bubble collapse.
// Define ADDER_FLAGS_EN to add the registered {N,Z,C,V} out_flags port.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c_out
`ifdef ADDER_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] out_flags
`endif
);

  localparam int unsigned S = slice_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) ||
      ((WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0)) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] room;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] leave;

  // Stage k can take a beat if any stage from k down to the output is empty, or the
  // output is being drained: this is what lets bubbles collapse without a comb loop.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * S;
    localparam int unsigned REM = WIDTH - LO;

    logic [REM-1:0]    a_src;
    logic [REM-1:0]    b_src;
    logic              c_src;
    logic [LO+S-1:0]   sum_nxt;
    logic [S-1:0]      s_slice;
    logic              c_out_slice;
    logic              c_msb_slice;
    logic              valid_q;
    logic              c_q;
    logic [LO+S-1:0]   sum_q;

    assign room[k]  = out_ready | ~(&valid[STAGES-1:k]);
    assign valid[k] = valid_q;

    if (k == 0) begin : g_head
      assign load[k]  = in_valid & room[k];
      assign a_src    = in_a;
      assign b_src    = in_b ^ {WIDTH{in_sub}};
      assign c_src    = in_c_in;
      assign sum_nxt  = s_slice;
    end else begin : g_body
      assign load[k]  = valid[k-1] & room[k];
      assign a_src    = g_stage[k-1].g_ops.a_q;
      assign b_src    = g_stage[k-1].g_ops.b_q;
      assign c_src    = g_stage[k-1].c_q;
      assign sum_nxt  = {s_slice, g_stage[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_leave_out
      assign leave[k] = valid[k] & out_ready;
    end else begin : g_leave_next
      assign leave[k] = load[k+1];
    end

    adder_slice #(.S(S)) u_slice (
      .a        (a_src[S-1:0]),
      .b        (b_src[S-1:0]),
      .c_in     (c_src),
      .s        (s_slice),
      .c_out    (c_out_slice),
      .c_msb_in (c_msb_slice)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= load[k] | (valid_q & ~leave[k]);
        if (load[k]) begin
          c_q   <= c_out_slice;
          sum_q <= sum_nxt;
        end
      end
    end

    // Only the operand bits later stages still need are carried forward.
    if (REM > S) begin : g_ops
      logic [REM-S-1:0] a_q;
      logic [REM-S-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load[k]) begin
          a_q <= a_src[REM-1:S];
          b_q <= b_src[REM-1:S];
        end
      end
    end

`ifdef ADDER_FLAGS_EN
    logic z_in;
    logic z_q;

    if (k == 0) begin : g_z_head
      assign z_in = 1'b1;
    end else begin : g_z_body
      assign z_in = g_stage[k-1].z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        z_q <= 1'b0;
      end else if (load[k]) begin
        z_q <= z_in & ~(|s_slice);
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (load[k]) begin
          v_q <= c_msb_slice ^ c_out_slice;
        end
      end
    end
`endif
  end

  assign in_ready  = room[0];
  assign out_valid = valid[STAGES-1];
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_c_out = g_stage[STAGES-1].c_q;

`ifdef ADDER_FLAGS_EN
  flags_t flags;

  always_comb begin
    flags   = '0;
    flags.n = out_sum[WIDTH-1];
    flags.z = g_stage[STAGES-1].z_q;
    flags.c = out_c_out;
    flags.v = g_stage[STAGES-1].g_ovf.v_q;
  end

  assign out_flags = flags;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: 32/4 main instance plus 8/1 and 64/8 instances,
// random stimulus checked against an arithmetic reference model.
module tb_pipe_adder;
  import adder_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned ST = 4;

  typedef struct packed {
    logic [63:0] sum;
    logic        c;
    logic [3:0]  f;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_sub, in_c_in, out_valid, out_ready, out_c_out;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic          v8, r8, sub8, ci8, ov8, or8, co8;
  logic [7:0]    a8, b8, sum8;
  logic          v64, r64, sub64, ci64, ov64, or64, co64;
  logic [63:0]   a64, b64, sum64;
`ifdef ADDER_FLAGS_EN
  logic [3:0]    out_flags, fl8, fl64;
`endif

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_c_in(in_c_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_c_out(out_c_out)
`ifdef ADDER_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_sub(sub8), .in_c_in(ci8),
    .out_valid(ov8), .out_ready(or8), .out_sum(sum8), .out_c_out(co8)
`ifdef ADDER_FLAGS_EN
    , .out_flags(fl8)
`endif
  );

  pipe_adder #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64),
    .in_a(a64), .in_b(b64), .in_sub(sub64), .in_c_in(ci64),
    .out_valid(ov64), .out_ready(or64), .out_sum(sum64), .out_c_out(co64)
`ifdef ADDER_FLAGS_EN
    , .out_flags(fl64)
`endif
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input logic [64:0] v, input int unsigned i);
    logic [64:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Reference: a + (b ^ {w{sub}}) + c_in on w-bit unsigned values, flags from the result.
  function automatic res_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic cin);
    logic [64:0] mask, full, am, bp;
    res_t r;
    mask    = (65'd1 << w) - 65'd1;
    am      = {1'b0, a} & mask;
    bp      = {1'b0, (sub ? ~b : b)} & mask;
    full    = am + bp + {64'd0, cin};
    r.sum   = full[63:0] & mask[63:0];
    r.c     = bit_at(full, w);
    r.f[3]  = bit_at({1'b0, r.sum}, w - 1);
    r.f[2]  = (r.sum == 64'd0);
    r.f[1]  = r.c;
    r.f[0]  = (bit_at(am, w - 1) == bit_at(bp, w - 1)) && (r.f[3] != bit_at(am, w - 1));
    return r;
  endfunction

  res_t q[$];
  res_t q8[$];
  res_t q64[$];
  int unsigned out_cnt = 0;
  logic        stall_q = 1'b0;
  logic [W-1:0] stall_sum = '0;

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      q.delete();
      q8.delete();
      q64.delete();
      stall_q = 1'b0;
    end else begin
      check("in_ready", in_ready, !(q.size() == ST && !out_ready));
      if (stall_q) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_sum", out_sum, stall_sum);
      end
      stall_q   = out_valid && !out_ready;
      stall_sum = out_sum;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (q.size() == 0) check("spurious_out", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          check("sum", out_sum, e.sum);
          check("c_out", out_c_out, e.c);
`ifdef ADDER_FLAGS_EN
          check("flags", out_flags, e.f);
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(W, {32'd0, in_a}, {32'd0, in_b}, in_sub, in_c_in));

      if (ov8 && or8) begin
        if (q8.size() == 0) check("spurious_out8", 1'b1, 1'b0);
        else begin
          e = q8.pop_front();
          check("sum8", {co8, sum8}, {e.c, e.sum[7:0]});
`ifdef ADDER_FLAGS_EN
          check("flags8", fl8, e.f);
`endif
        end
      end
      if (v8 && r8) q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, sub8, ci8));

      if (ov64 && or64) begin
        if (q64.size() == 0) check("spurious_out64", 1'b1, 1'b0);
        else begin
          e = q64.pop_front();
          check("sum64", {co64, sum64}, {e.c, e.sum});
`ifdef ADDER_FLAGS_EN
          check("flags64", fl64, e.f);
`endif
        end
      end
      if (v64 && r64) q64.push_back(model(64, a64, b64, sub64, ci64));
    end
  end

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic cin, output int unsigned lat);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_sub = sub; in_c_in = cin; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      in_valid = 1'b0;
      @(negedge clk);
    end while (!out_valid && lat < 20);
  endtask

  task automatic stream_main(input int unsigned n);
    int unsigned sent = 0;
    int unsigned cyc  = 0;
    logic took = 1'b0;
    while ((sent < n || q.size() != 0) && cyc < 50 * n) begin
      @(posedge clk); #1; cyc++;
      if (!in_valid || took) begin
        if (sent < n && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1; in_sub = 1'($urandom_range(0, 1)); in_c_in = 1'($urandom_range(0, 1));
        end else in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      took = in_valid && in_ready;
      if (took) sent++;
    end
    out_ready = 1'b1;
    check("stream_sent", sent, n);
    check("stream_drain", q.size(), 0);
  endtask

  task automatic run_params(input int unsigned n);
    int unsigned s8 = 0, s64 = 0, cyc = 0;
    logic t8 = 1'b0, t64 = 1'b0;
    while ((s8 < n || s64 < n || q8.size() != 0 || q64.size() != 0) && cyc < 20 * n) begin
      @(posedge clk); #1; cyc++;
      if (!v8 || t8) begin
        v8 = (s8 < n) && ($urandom_range(0, 3) != 0);
        a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'($urandom_range(0, 1)); ci8 = 1'($urandom_range(0, 1));
      end
      if (!v64 || t64) begin
        v64 = (s64 < n) && ($urandom_range(0, 3) != 0);
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        sub64 = 1'($urandom_range(0, 1)); ci64 = 1'($urandom_range(0, 1));
      end
      or8  = ($urandom_range(0, 5) != 0);
      or64 = ($urandom_range(0, 5) != 0);
      @(negedge clk); #1;
      t8  = v8 && r8;
      t64 = v64 && r64;
      if (t8) s8++;
      if (t64) s64++;
    end
    check("p8_sent", s8, n);
    check("p64_sent", s64, n);
    check("p8_drain", q8.size(), 0);
    check("p64_drain", q64.size(), 0);
  endtask

  initial begin
    int unsigned lat, base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_c_in = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; ci8 = 1'b0; or8 = 1'b1;
    v64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; ci64 = 1'b0; or64 = 1'b1;

    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_c_out", out_c_out, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef ADDER_FLAGS_EN
    check("rst_flags", out_flags, 4'd0);
`endif
    @(negedge clk); #2 rst_n = 1'b1;

    single(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
    check("add_latency", lat, ST);
    check("add_sum", out_sum, 32'd0);
    check("add_c_out", out_c_out, 1'b1);
`ifdef ADDER_FLAGS_EN
    check("add_flags", out_flags, 4'b0110);
`endif
    single(32'd5, 32'd7, 1'b1, 1'b1, lat);
    check("sub_latency", lat, ST);
    check("sub_sum", out_sum, 32'hFFFF_FFFE);
    check("sub_c_out", out_c_out, 1'b0);
`ifdef ADDER_FLAGS_EN
    check("sub_flags", out_flags, 4'b1000);
`endif
    single(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
    check("ovf_sum", out_sum, 32'h8000_0000);
    check("ovf_c_out", out_c_out, 1'b0);
`ifdef ADDER_FLAGS_EN
    check("ovf_flags", out_flags, 4'b1001);
`endif

    // Three beats in flight, then reset before any reaches the output.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'b0; in_c_in = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_sum", out_sum, 32'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    base = out_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    check("midrst_no_emerge", out_cnt - base, 0);

    stream_main(40);

    out_ready = 1'b1;
    base = out_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      in_sub = 1'($urandom_range(0, 1)); in_c_in = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (ST - 1) @(posedge clk);
    @(negedge clk); #1;
    check("throughput_count", out_cnt - base, 20);
    repeat (ST + 2) @(posedge clk);

    run_params(1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
